n2_bcd_digit_collector: RTL
===========================

Name: n2_bcd_digit_collector

Overview:
- Upstream entry stage for the 2-digit BCD-to-binary converter. Collects decimal digits one at a time from a keypad/serial source using a valid/ready handshake.
- Rejects non-BCD codes and holds a tens/units digit pair on registered outputs, which drive the converter's a3_a0/b3_b0 inputs directly.
- Signals a complete number with out_valid and holds it until the consumer acknowledges.

Parameters:
- none (format fixed at 2 BCD digits, 4 bits each)

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- d3_d0  input  4  incoming digit code
- d_valid  input  1  d3_d0 carries a digit this cycle
- d_ready  output  1  block can accept a digit this cycle
- enter  input  1  finalize a 1-digit number (tens forced to 0)
- clr  input  1  discard the partial or complete number
- a3_a0  output  4  tens digit (registered), feeds converter a3_a0
- b3_b0  output  4  units digit (registered), feeds converter b3_b0
- out_valid  output  1  a3_a0/b3_b0 hold a complete number
- out_ack  input  1  consumer has taken the number
- err  output  1  one-cycle pulse: rejected digit code (>9)

Behaviour:
- One clock and one reset: reset is synchronous and active-high. All outputs are registered or decoded from registered state.
- Reset or clr: state EMPTY, a3_a0=0, b3_b0=0, out_valid=0, err=0. d_ready=1 from the next cycle.
- States:
  - EMPTY: d_ready=1, out_valid=0.
  - ONE: d_ready=1, out_valid=0.
  - FULL: d_ready=0, out_valid=1.
- Acceptance: a digit is accepted when d_valid=1 and d_ready=1 on a rising edge.
- Accepted digit ≤9:
  - EMPTY -> ONE, b3_b0 <= d, a3_a0 <= 0.
  - ONE -> FULL, a3_a0 <= old b3_b0, b3_b0 <= d (calculator-style left shift).
- Accepted digit >9: consumed (handshake completes), registers and state unchanged. err=1 for exactly the next cycle.
- enter:
  - Evaluated only in a cycle with no accepted digit.
  - ONE: -> FULL with a3_a0=0, b3_b0 unchanged.
  - EMPTY or FULL: ignored.
  - enter together with an accepted valid digit in ONE: the digit wins, -> FULL with shift.
  - enter together with a rejected digit in ONE: enter applies, err also pulses.
- FULL:
  - d_valid is ignored; no err, no change.
  - out_ack=1 -> EMPTY, registers cleared to 0, out_valid=0 next cycle. Latency ack->d_ready=1 is 1 cycle.
- out_ack outside FULL: ignored.
- Priority: reset > clr > out_ack > digit > enter. clr with out_ack in the same cycle: clear, same result.
- Latency: outputs reflect an accepted digit 1 cycle after the accepting edge. out_valid rises on the edge that accepts the 2nd digit or applies enter.
- In ONE, a3_a0=0 and b3_b0=digit, so the downstream converter already shows the 1-digit value with out_valid=0.
- err never stays high for 2 consecutive cycles unless a rejected digit is accepted each cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset, then digits 4 and 7 in consecutive cycles with d_valid=1 -> a3_a0=4, b3_b0=7, out_valid=1, d_ready=0; converter output 47. out_ack -> next cycle all zero, EMPTY.
- Digit 9, then enter -> a3_a0=0, b3_b0=9, out_valid=1. enter asserted again in EMPTY after ack -> no change.
- Digit 3, then code 4'b1100, then 5 -> err pulses 1 cycle after 1100, state stays ONE. Final a3_a0=3, b3_b0=5.
- In FULL holding 8,1, present digit 2 with d_valid=1 for 3 cycles -> d_ready=0, outputs stay 8,1, no err.
- Digit 6, then clr and d_valid(2) in the same cycle -> EMPTY, outputs 0, digit 2 not captured.
- In ONE (digit 5), reset asserted with d_valid(7) -> all outputs 0 next cycle, state EMPTY, d_ready=1.

Source files
------------

// File: rtl/n2_bcd_digit_collector.sv
// n2_bcd_digit_collector
// Collects up to two BCD digits over a valid/ready handshake. The pair is
// held on registered tens/units outputs that feed the BCD-to-binary converter.
// A complete number is flagged with out_valid and held until out_ack.
module n2_bcd_digit_collector (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d3_d0,
    input  logic       d_valid,
    output logic       d_ready,
    input  logic       enter,
    input  logic       clr,
    output logic [3:0] a3_a0,
    output logic [3:0] b3_b0,
    output logic       out_valid,
    input  logic       out_ack,
    output logic       err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] tens_next;
    logic [3:0] units_next;
    logic       err_next;
    logic       digit_ok;

    // Handshake and status flags are decoded purely from the registered state,
    // so no input reaches an output combinationally.
    assign d_ready   = (state != FULL);
    assign out_valid = (state == FULL);
    assign digit_ok  = (d3_d0 <= 4'd9);

    // State, digit and error registers; reset returns everything to EMPTY/zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            a3_a0 <= 4'd0;
            b3_b0 <= 4'd0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            a3_a0 <= tens_next;
            b3_b0 <= units_next;
            err   <= err_next;
        end
    end

    // Next-state logic: clr beats out_ack, which beats a digit, which beats enter.
    always_comb begin
        state_next = state;
        tens_next  = a3_a0;
        units_next = b3_b0;
        err_next   = 1'b0;

        if (clr) begin
            state_next = EMPTY;
            tens_next  = 4'd0;
            units_next = 4'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (d_valid) begin
                        if (digit_ok) begin
                            state_next = ONE;
                            tens_next  = 4'd0;
                            units_next = d3_d0;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                ONE: begin
                    if (d_valid && digit_ok) begin
                        state_next = FULL;
                        tens_next  = b3_b0;
                        units_next = d3_d0;
                    end else begin
                        if (d_valid) begin
                            err_next = 1'b1;
                        end
                        if (enter) begin
                            state_next = FULL;
                            tens_next  = 4'd0;
                        end
                    end
                end
                FULL: begin
                    if (out_ack) begin
                        state_next = EMPTY;
                        tens_next  = 4'd0;
                        units_next = 4'd0;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    tens_next  = 4'd0;
                    units_next = 4'd0;
                end
            endcase
        end
    end

endmodule
